// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// loads the IF/ID register consumed by decode, honouring decode's stall and redirect.
module i_fetch #(
    parameter logic [0:31] RESET_PC  = 32'h0000_0000,
    parameter logic [0:31] NOP_INSTR = 32'h5400_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [0:31] redirect_target,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    output logic [0:31] instruction,
    output logic [0:31] pc_plus_four,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [0:31] pc, pc_nxt, pc_inc;
    logic [0:31] hold_buf;
    logic [0:31] drain_addr;
    logic [0:31] ifid_word;
    logic        load_ifid, bubble_ifid, load_hold, load_drain;
    logic        take_redirect;

    // Stall has priority: decode re-presents the branch once it releases.
    assign take_redirect = redirect && !stall;
    assign pc_inc        = pc + 32'd4;

    // run stays low through reset and the first edge after it, so no request
    // is visible until one clock after rst_n deasserts.
    assign imem_req  = run && (state != HOLD);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ifid_word   = imem_rdata;
        load_ifid   = 1'b0;
        bubble_ifid = 1'b0;
        load_hold   = 1'b0;
        load_drain  = 1'b0;
        case (state)
            FETCH: begin
                if (run) begin
                    if (take_redirect) begin
                        bubble_ifid = 1'b1;
                        pc_nxt      = redirect_target;
                        // The in-flight request must still complete at its old address.
                        if (!imem_ack) begin
                            load_drain = 1'b1;
                            state_nxt  = DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            load_hold = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            load_ifid = 1'b1;
                            pc_nxt    = pc_inc;
                        end
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_nxt = FETCH;
                    if (redirect) begin
                        bubble_ifid = 1'b1;
                        pc_nxt      = redirect_target;
                    end else begin
                        load_ifid = 1'b1;
                        ifid_word = hold_buf;
                        pc_nxt    = pc_inc;
                    end
                end
            end
            DRAIN: begin
                if (take_redirect)
                    pc_nxt = redirect_target;
                if (imem_ack)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            run   <= 1'b0;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_buf   <= '0;
            drain_addr <= '0;
        end else begin
            if (load_hold)
                hold_buf <= imem_rdata;
            if (load_drain)
                drain_addr <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction  <= NOP_INSTR;
            pc_plus_four <= '0;
            if_valid     <= 1'b0;
        end else if (bubble_ifid) begin
            instruction  <= NOP_INSTR;
            pc_plus_four <= '0;
            if_valid     <= 1'b0;
        end else if (load_ifid) begin
            instruction  <= ifid_word;
            pc_plus_four <= pc_inc;
            if_valid     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i_fetch.sv
// Bench for i_fetch: directed walk through the fetch scenarios, then random
// stall/redirect/latency traffic checked cycle by cycle against a queue-based model.
module tb_i_fetch;

    localparam logic [31:0] NOP = 32'h5400_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [0:31] redirect_target = '0;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_ack = 1'b0;
    logic [0:31] imem_rdata = '0;
    logic [0:31] instruction;
    logic [0:31] pc_plus_four;
    logic        if_valid;

    logic        req2;
    logic [0:31] addr2;
    logic        ack2;
    logic [0:31] rdata2;
    logic [0:31] instr2;
    logic [0:31] ppf2;
    logic        v2;

    i_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
        .pc_plus_four(pc_plus_four), .if_valid(if_valid)
    );

    // Second instance exercises PC wrap-around from the top of the address space.
    i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
        .redirect_target(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .instruction(instr2),
        .pc_plus_four(ppf2), .if_valid(v2)
    );
    assign ack2   = req2;
    assign rdata2 = addr2 | 32'h1000;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the stage as a PC plus two small queues -- a word parked
    // by a stall, and an abandoned request whose ack is still owed.
    bit          m_started;
    logic [31:0] m_pc;
    logic [31:0] q_held[$];
    logic [31:0] q_stale[$];
    logic [31:0] m_instr, m_ppf;
    bit          m_valid;
    int          lat;
    int          wcnt;
    bit          rand_data;

    function automatic void model_reset();
        m_started = 0;
        m_pc      = 32'h0;
        q_held.delete();
        q_stale.delete();
        m_instr   = NOP;
        m_ppf     = 0;
        m_valid   = 0;
        wcnt      = 0;
    endfunction

    function automatic bit exp_req();
        return m_started && (q_held.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return (q_stale.size() != 0) ? q_stale[0] : m_pc;
    endfunction

    function automatic void squash();
        m_instr = NOP; m_ppf = 0; m_valid = 0;
    endfunction

    function automatic void deliver(input logic [31:0] w);
        m_instr = w; m_ppf = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
    endfunction

    function automatic void model_edge(input bit s, input bit r, input logic [31:0] t,
                                       input bit a, input logic [31:0] d);
        if (!m_started) begin
            m_started = 1;
        end else if (q_held.size() != 0) begin
            if (!s) begin
                if (r) begin squash(); m_pc = t; end
                else deliver(q_held[0]);
                q_held.delete();
            end
        end else if (q_stale.size() != 0) begin
            if (!s && r) m_pc = t;
            if (a) q_stale.delete();
        end else if (s) begin
            if (a) q_held.push_back(d);
        end else if (r) begin
            if (!a) q_stale.push_back(m_pc);
            squash();
            m_pc = t;
        end else if (a) begin
            deliver(d);
        end
    endfunction

    // Entered at a negedge: compare, drive memory + decode inputs, advance one clock.
    task automatic step(input bit s, input bit r, input logic [31:0] t);
        bit          a;
        logic [31:0] d;
        chk("req",   {31'b0, imem_req}, {31'b0, exp_req()});
        chk("addr",  imem_addr, exp_addr());
        chk("instr", instruction, m_instr);
        chk("ppf",   pc_plus_four, m_ppf);
        chk("valid", {31'b0, if_valid}, {31'b0, m_valid});
        a = exp_req() && (wcnt >= lat);
        d = rand_data ? $urandom : (exp_addr() | 32'h1000);
        imem_ack = a; imem_rdata = d;
        stall = s; redirect = r; redirect_target = t;
        @(posedge clk);
        if (rst_n) begin
            model_edge(s, r, t, a, d);
            if (exp_req() && !a) wcnt++;
            else wcnt = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        lat = 0;
        rand_data = 0;
        repeat (2) @(negedge clk);
        step(0, 0, 0);
        rst_n = 1'b1;

        // Zero-wait streaming from RESET_PC.
        step(0, 0, 0);
        chk("start_addr0", imem_addr, 32'h0);
        chk("wrap_req", {31'b0, req2}, 32'h1);
        chk("wrap_addr", addr2, 32'hFFFF_FFFC);
        step(0, 0, 0);
        chk("start_addr4", imem_addr, 32'h4);
        chk("start_instr", instruction, 32'h1000);
        chk("wrap_ppf", ppf2, 32'h0);
        chk("wrap_next_addr", addr2, 32'h0);
        step(0, 0, 0);
        chk("start_addr8", imem_addr, 32'h8);
        chk("start_ppf8", pc_plus_four, 32'h8);

        // Three-cycle stall landing on the ack of address 8.
        step(1, 0, 0);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_frozen", instruction, 32'h1004);
        step(1, 1, 32'h40);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("release_instr", instruction, 32'h1008);
        chk("release_ppf", pc_plus_four, 32'hC);
        chk("release_addr", imem_addr, 32'hC);

        // Zero-wait redirect: one bubble.
        step(0, 1, 32'h100);
        chk("redir_bubble", instruction, NOP);
        chk("redir_addr", imem_addr, 32'h100);
        step(0, 0, 0);
        chk("redir_instr", instruction, 32'h1100);
        chk("redir_ppf", pc_plus_four, 32'h104);

        // Slow memory: redirect while the fetch of 8 is outstanding.
        step(0, 1, 32'h8);
        lat = 3; wcnt = 0;
        step(0, 0, 0);
        step(0, 1, 32'h200);
        chk("drain_addr_a", imem_addr, 32'h8);
        step(0, 0, 0);
        chk("drain_addr_b", imem_addr, 32'h8);
        step(0, 0, 0);
        chk("drain_done_addr", imem_addr, 32'h200);
        chk("drain_bubble", {31'b0, if_valid}, 32'h0);

        // Asynchronous reset while draining.
        step(0, 1, 32'h300);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'b0, imem_req}, 32'h0);
        chk("async_instr", instruction, NOP);
        chk("async_valid", {31'b0, if_valid}, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        model_reset();
        lat = 0;
        @(negedge clk);
        step(0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("resume_addr", imem_addr, 32'h0);
        step(0, 0, 0);
        chk("resume_instr", instruction, 32'h1000);

        // Random traffic.
        rand_data = 1;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            if (i % 60 == 0) lat = $urandom_range(0, 3);
            tgt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            if (i == 300) begin
                #3 rst_n = 1'b0;
                #1 chk("rand_rst_req", {31'b0, imem_req}, 32'h0);
                model_reset();
                @(negedge clk);
                step(0, 0, 0);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
